// File: rtl/forwarding_scoreboard.sv
// Operand-forwarding scoreboard for a multi-lane in-order pipeline.
// Tracks EX/MEM/WB register tags, produces forward selects, load-use stalls and a stall counter.
module forwarding_scoreboard #(
  parameter int LANES = 2,
  parameter int CNT_W = 16,
  localparam int SELW = $clog2(2*LANES+1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES-1:0]        id_valid,
  input  logic [LANES-1:0]        id_regwrite,
  input  logic [LANES-1:0]        id_is_load,
  input  logic [LANES-1:0]        id_is_store,
  input  logic [5*LANES-1:0]      id_dest,
  input  logic [5*LANES-1:0]      id_rs,
  input  logic [5*LANES-1:0]      id_rt,
  input  logic                    ext_stall,
  input  logic                    flush,
  input  logic                    cnt_clr,
  output logic [SELW*LANES-1:0]   fwd_a,
  output logic [SELW*LANES-1:0]   fwd_b,
  output logic [SELW*LANES-1:0]   mem_fwd,
  output logic                    load_use_stall,
  output logic [LANES-1:0]        bundle_conflict,
  output logic [CNT_W-1:0]        stall_count
);

  // Only the tag fields consumed downstream are carried past EX.
  logic [LANES-1:0] vld_p0, vld_p1, vld_p2;
  logic [LANES-1:0] rw_p0, rw_p1, rw_p2;
  logic [LANES-1:0] ld_p0;
  logic [LANES-1:0] st_p0, st_p1;
  logic [4:0]       dest_p0 [LANES];
  logic [4:0]       dest_p1 [LANES];
  logic [4:0]       dest_p2 [LANES];
  logic [4:0]       rs_p0   [LANES];
  logic [4:0]       rt_p0   [LANES];
  logic [4:0]       rt_p1   [LANES];

  function automatic logic hit(input logic v, input logic rw,
                               input logic [4:0] dest, input logic [4:0] src);
    return v && rw && (dest != 5'd0) && (dest == src);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // ID -> EX (p0), EX -> MEM (p1), MEM -> WB (p2): valid bits and counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0      <= '0;
      vld_p1      <= '0;
      vld_p2      <= '0;
      stall_count <= '0;
    end else begin
      if (!ext_stall) begin
        vld_p2 <= vld_p1;
        vld_p1 <= vld_p0;
        vld_p0 <= (flush || load_use_stall) ? '0 : id_valid;
      end else if (flush) begin
        vld_p0 <= '0;
      end
      if (cnt_clr)
        stall_count <= '0;
      else if (load_use_stall && !ext_stall)
        stall_count <= sat_inc(stall_count);
    end
  end

  // Tag payload; meaningless while the matching valid bit is low, so no reset
  always_ff @(posedge clk) begin
    if (!ext_stall) begin
      rw_p0 <= id_regwrite;
      ld_p0 <= id_is_load;
      st_p0 <= id_is_store;
      for (int k = 0; k < LANES; k++) begin
        dest_p0[k] <= id_dest[5*k +: 5];
        rs_p0[k]   <= id_rs[5*k +: 5];
        rt_p0[k]   <= id_rt[5*k +: 5];
      end
      rw_p1   <= rw_p0;
      st_p1   <= st_p0;
      dest_p1 <= dest_p0;
      rt_p1   <= rt_p0;
      rw_p2   <= rw_p1;
      dest_p2 <= dest_p1;
    end
  end

  // Forward selects: WB scanned first so MEM overrides; ascending lanes so younger wins
  always_comb begin
    fwd_a   = '0;
    fwd_b   = '0;
    mem_fwd = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < LANES; j++) begin
        if (hit(vld_p2[j], rw_p2[j], dest_p2[j], rs_p0[k]))
          fwd_a[SELW*k +: SELW] = SELW'(1 + LANES + j);
        if (hit(vld_p2[j], rw_p2[j], dest_p2[j], rt_p0[k]))
          fwd_b[SELW*k +: SELW] = SELW'(1 + LANES + j);
      end
      for (int j = 0; j < LANES; j++) begin
        if (hit(vld_p1[j], rw_p1[j], dest_p1[j], rs_p0[k]))
          fwd_a[SELW*k +: SELW] = SELW'(1 + j);
        if (hit(vld_p1[j], rw_p1[j], dest_p1[j], rt_p0[k]))
          fwd_b[SELW*k +: SELW] = SELW'(1 + j);
      end
      if (vld_p1[k] && st_p1[k]) begin
        for (int j = 0; j < LANES; j++) begin
          if (hit(vld_p2[j], rw_p2[j], dest_p2[j], rt_p1[k]))
            mem_fwd[SELW*k +: SELW] = SELW'(1 + LANES + j);
        end
      end
    end
  end

  // Hazard detection against the ID bundle
  always_comb begin
    load_use_stall  = 1'b0;
    bundle_conflict = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < LANES; j++) begin
        if (vld_p0[i] && ld_p0[i] && (dest_p0[i] != 5'd0) && id_valid[j] &&
            ((dest_p0[i] == id_rs[5*j +: 5]) || (dest_p0[i] == id_rt[5*j +: 5])))
          load_use_stall = 1'b1;
      end
    end
    for (int j = 1; j < LANES; j++) begin
      for (int i = 0; i < j; i++) begin
        if (id_valid[i] && id_regwrite[i] && (id_dest[5*i +: 5] != 5'd0) &&
            ((id_dest[5*i +: 5] == id_rs[5*j +: 5]) || (id_dest[5*i +: 5] == id_rt[5*j +: 5])))
          bundle_conflict[j] = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed testbench for forwarding_scoreboard (LANES=2); a second instance with CNT_W=2
// shares all inputs to exercise counter saturation.
module tb_forwarding_scoreboard;
  localparam int LANES = 2;
  localparam int SELW  = 3;

  logic clk, rst;
  logic [LANES-1:0] id_valid, id_regwrite, id_is_load, id_is_store;
  logic [5*LANES-1:0] id_dest, id_rs, id_rt;
  logic ext_stall, flush, cnt_clr;
  logic [SELW*LANES-1:0] fwd_a, fwd_b, mem_fwd;
  logic [SELW*LANES-1:0] fwd_a2, fwd_b2, mem_fwd2;
  logic lus, lus2;
  logic [LANES-1:0] bc, bc2;
  logic [15:0] stall_count;
  logic [1:0]  stall_count2;

  int total = 0;
  int bad = 0;

  forwarding_scoreboard #(.LANES(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .id_dest(id_dest),
    .id_rs(id_rs), .id_rt(id_rt), .ext_stall(ext_stall), .flush(flush),
    .cnt_clr(cnt_clr), .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_fwd(mem_fwd),
    .load_use_stall(lus), .bundle_conflict(bc), .stall_count(stall_count));

  forwarding_scoreboard #(.LANES(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .id_is_store(id_is_store), .id_dest(id_dest),
    .id_rs(id_rs), .id_rt(id_rt), .ext_stall(ext_stall), .flush(flush),
    .cnt_clr(cnt_clr), .fwd_a(fwd_a2), .fwd_b(fwd_b2), .mem_fwd(mem_fwd2),
    .load_use_stall(lus2), .bundle_conflict(bc2), .stall_count(stall_count2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_id();
    id_valid = '0; id_regwrite = '0; id_is_load = '0; id_is_store = '0;
    id_dest = '0; id_rs = '0; id_rt = '0;
  endtask

  task automatic set_lane(input int k, input logic rw, input logic ld, input logic st,
                          input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    id_valid[k] = 1'b1; id_regwrite[k] = rw; id_is_load[k] = ld; id_is_store[k] = st;
    id_dest[5*k +: 5] = d; id_rs[5*k +: 5] = s; id_rt[5*k +: 5] = t;
  endtask

  task automatic drain();
    clear_id();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    clear_id();
    set_lane(0, 1, 0, 0, 5'd9, 5'd0, 5'd0);
    set_lane(1, 0, 0, 0, 5'd0, 5'd9, 5'd0);
    #3;
    total++; if (fwd_a !== 6'o00) begin bad++; $display("FAIL rst_fwd_a got %o want 0", fwd_a); end
    total++; if (fwd_b !== 6'o00) begin bad++; $display("FAIL rst_fwd_b got %o want 0", fwd_b); end
    total++; if (mem_fwd !== 6'o00) begin bad++; $display("FAIL rst_mem_fwd got %o want 0", mem_fwd); end
    total++; if (lus !== 1'b0) begin bad++; $display("FAIL rst_stall got %b want 0", lus); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL rst_count got %0d want 0", stall_count); end
    total++; if (bc !== 2'b10) begin bad++; $display("FAIL rst_bundle got %b want 10", bc); end
    tick(); tick();
    clear_id();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mem_wb_fwd();
    set_lane(0, 1, 0, 0, 5'd5, 5'd0, 5'd0); tick();
    clear_id(); set_lane(1, 0, 0, 0, 5'd0, 5'd5, 5'd0); tick();
    clear_id(); settle();
    total++; if (fwd_a !== {3'd1, 3'd0}) begin bad++; $display("FAIL mem_fwd_a got %o want 10", fwd_a); end
    total++; if (fwd_b !== 6'o00) begin bad++; $display("FAIL mem_fwd_b got %o want 0", fwd_b); end
    drain();
    set_lane(0, 1, 0, 0, 5'd5, 5'd0, 5'd0); tick();
    clear_id(); tick();
    set_lane(1, 0, 0, 0, 5'd0, 5'd5, 5'd0); tick();
    clear_id(); settle();
    total++; if (fwd_a !== {3'd3, 3'd0}) begin bad++; $display("FAIL wb_fwd_a got %o want 30", fwd_a); end
    drain();
  endtask

  task automatic test_priority();
    set_lane(0, 1, 0, 0, 5'd7, 5'd0, 5'd0);
    set_lane(1, 1, 0, 0, 5'd7, 5'd0, 5'd0); tick();
    clear_id(); set_lane(0, 0, 0, 0, 5'd0, 5'd0, 5'd7); tick();
    clear_id(); settle();
    total++; if (fwd_b !== {3'd0, 3'd2}) begin bad++; $display("FAIL lane_prio_b got %o want 02", fwd_b); end
    total++; if (fwd_a !== 6'o00) begin bad++; $display("FAIL lane_prio_a got %o want 0", fwd_a); end
    drain();
    set_lane(1, 1, 0, 0, 5'd7, 5'd0, 5'd0); tick();
    clear_id(); set_lane(0, 1, 0, 0, 5'd7, 5'd0, 5'd0); tick();
    clear_id(); set_lane(0, 0, 0, 0, 5'd0, 5'd7, 5'd7); tick();
    clear_id(); settle();
    total++; if (fwd_a !== {3'd0, 3'd1}) begin bad++; $display("FAIL stage_prio_a got %o want 01", fwd_a); end
    total++; if (fwd_b !== {3'd0, 3'd1}) begin bad++; $display("FAIL stage_prio_b got %o want 01", fwd_b); end
    drain();
  endtask

  task automatic test_load_use();
    set_lane(0, 1, 1, 0, 5'd3, 5'd0, 5'd0); tick();
    clear_id(); set_lane(1, 0, 0, 0, 5'd0, 5'd3, 5'd0); settle();
    total++; if (lus !== 1'b1) begin bad++; $display("FAIL lu_stall got %b want 1", lus); end
    ext_stall = 1'b1; tick(); settle();
    total++; if (lus !== 1'b1) begin bad++; $display("FAIL lu_held got %b want 1", lus); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL lu_ext_count got %0d want 0", stall_count); end
    ext_stall = 1'b0; tick(); settle();
    total++; if (lus !== 1'b0) begin bad++; $display("FAIL lu_one_cycle got %b want 0", lus); end
    total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_count got %0d want 1", stall_count); end
    total++; if (stall_count2 !== 2'd1) begin bad++; $display("FAIL lu_count2 got %0d want 1", stall_count2); end
    tick(); clear_id(); settle();
    total++; if (fwd_a !== {3'd3, 3'd0}) begin bad++; $display("FAIL lu_wb_fwd got %o want 30", fwd_a); end
    total++; if (lus !== 1'b0) begin bad++; $display("FAIL lu_after got %b want 0", lus); end
    drain();
  endtask

  task automatic test_bundle_r0();
    set_lane(0, 1, 0, 0, 5'd9, 5'd0, 5'd0);
    set_lane(1, 0, 0, 0, 5'd0, 5'd9, 5'd0); settle();
    total++; if (bc !== 2'b10) begin bad++; $display("FAIL bundle_raw got %b want 10", bc); end
    total++; if (lus !== 1'b0) begin bad++; $display("FAIL bundle_stall got %b want 0", lus); end
    clear_id();
    set_lane(0, 0, 0, 0, 5'd0, 5'd9, 5'd9);
    set_lane(1, 1, 0, 0, 5'd9, 5'd0, 5'd0); settle();
    total++; if (bc !== 2'b00) begin bad++; $display("FAIL bundle_order got %b want 00", bc); end
    clear_id();
    set_lane(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    set_lane(1, 1, 0, 0, 5'd0, 5'd0, 5'd0); settle();
    total++; if (bc !== 2'b00) begin bad++; $display("FAIL bundle_r0 got %b want 00", bc); end
    tick();
    clear_id(); set_lane(0, 0, 0, 0, 5'd0, 5'd0, 5'd0); settle();
    total++; if (lus !== 1'b0) begin bad++; $display("FAIL r0_stall got %b want 0", lus); end
    tick(); clear_id(); settle();
    total++; if ({fwd_a, fwd_b} !== 12'o0000) begin bad++; $display("FAIL r0_fwd got %o want 0", {fwd_a, fwd_b}); end
    drain();
  endtask

  task automatic test_flush();
    set_lane(0, 1, 0, 0, 5'd6, 5'd0, 5'd0); flush = 1'b1; tick();
    flush = 1'b0; clear_id(); set_lane(1, 0, 0, 0, 5'd0, 5'd6, 5'd0); tick();
    clear_id(); settle();
    total++; if (fwd_a !== 6'o00) begin bad++; $display("FAIL flush_kill got %o want 0", fwd_a); end
    drain();
  endtask

  task automatic test_store_ext_stall();
    set_lane(0, 1, 0, 0, 5'd4, 5'd0, 5'd0); tick();
    clear_id(); set_lane(1, 0, 0, 1, 5'd0, 5'd0, 5'd4); tick();
    clear_id(); settle();
    total++; if (fwd_b !== {3'd1, 3'd0}) begin bad++; $display("FAIL store_ex_fwd got %o want 10", fwd_b); end
    tick(); settle();
    total++; if (mem_fwd !== {3'd3, 3'd0}) begin bad++; $display("FAIL store_mem_fwd got %o want 30", mem_fwd); end
    ext_stall = 1'b1;
    set_lane(0, 1, 0, 0, 5'd8, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      total++; if (mem_fwd !== {3'd3, 3'd0}) begin bad++; $display("FAIL hold_mem_fwd cyc%0d got %o want 30", i, mem_fwd); end
      total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL hold_count cyc%0d got %0d want 1", i, stall_count); end
    end
    ext_stall = 1'b0; clear_id(); tick(); settle();
    total++; if (mem_fwd !== 6'o00) begin bad++; $display("FAIL store_retired got %o want 0", mem_fwd); end
    drain();
  endtask

  task automatic test_saturation_reset();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0; settle();
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL clr_count got %0d want 0", stall_count); end
    set_lane(0, 1, 1, 0, 5'd3, 5'd0, 5'd0);
    set_lane(1, 0, 0, 0, 5'd0, 5'd3, 5'd0);
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) begin
        total++; if (stall_count2 !== 2'd2) begin bad++; $display("FAIL sat_mid got %0d want 2", stall_count2); end
      end
    end
    settle();
    total++; if (stall_count !== 16'd5) begin bad++; $display("FAIL sat_wide got %0d want 5", stall_count); end
    total++; if (stall_count2 !== 2'd3) begin bad++; $display("FAIL sat_narrow got %0d want 3", stall_count2); end
    tick(); settle();
    total++; if (lus !== 1'b1) begin bad++; $display("FAIL clr_pre_stall got %b want 1", lus); end
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0; settle();
    total++; if (stall_count2 !== 2'd0) begin bad++; $display("FAIL clr_prio got %0d want 0", stall_count2); end
    repeat (3) tick();
    settle();
    total++; if (lus !== 1'b1) begin bad++; $display("FAIL pre_rst_stall got %b want 1", lus); end
    total++; if (fwd_a !== {3'd3, 3'd0}) begin bad++; $display("FAIL pre_rst_fwd got %o want 30", fwd_a); end
    total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL pre_rst_count got %0d want 1", stall_count); end
    #2; rst = 1'b1; #1;
    total++; if (lus !== 1'b0) begin bad++; $display("FAIL async_rst_stall got %b want 0", lus); end
    total++; if (fwd_a !== 6'o00) begin bad++; $display("FAIL async_rst_fwd got %o want 0", fwd_a); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL async_rst_count got %0d want 0", stall_count); end
    total++; if (bc !== 2'b10) begin bad++; $display("FAIL async_rst_bundle got %b want 10", bc); end
    #1; rst = 1'b0;
    clear_id(); set_lane(1, 0, 0, 0, 5'd0, 5'd3, 5'd3); tick();
    clear_id(); settle();
    total++; if ({fwd_a, fwd_b} !== 12'o0000) begin bad++; $display("FAIL post_rst_fwd got %o want 0", {fwd_a, fwd_b}); end
    total++; if (lus !== 1'b0) begin bad++; $display("FAIL post_rst_stall got %b want 0", lus); end
  endtask

  initial begin
    test_reset();
    test_mem_wb_fwd();
    test_priority();
    test_load_use();
    test_bundle_r0();
    test_flush();
    test_store_ext_stall();
    test_saturation_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
